// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into a 2-entry skid FIFO of decoded beats.
// in_ready is registered from the next-cycle occupancy, so it never depends on out_ready combinationally.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0,
  parameter int PC_W     = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_op,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal,
  output logic [PC_W-1:0] out_pc
);

  typedef struct packed {
    logic [5:0]      op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic [PC_W-1:0] pc;
  } beat_t;

  function automatic logic signed [XLEN-1:0] widen(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic signed [XLEN-1:0] imm_i(input logic [31:0] i);
    return widen({{20{i[31]}}, i[31:20]});
  endfunction

  function automatic logic signed [XLEN-1:0] imm_s(input logic [31:0] i);
    return widen({{20{i[31]}}, i[31:25], i[11:7]});
  endfunction

  function automatic logic signed [XLEN-1:0] imm_b(input logic [31:0] i);
    return widen({{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0});
  endfunction

  function automatic logic signed [XLEN-1:0] imm_u(input logic [31:0] i);
    return widen({i[31:12], 12'b0});
  endfunction

  function automatic logic signed [XLEN-1:0] imm_j(input logic [31:0] i);
    return widen({{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0});
  endfunction

  // ---- p0: combinational decode of the incoming word ----
  logic [6:0] opcode_p0;
  logic [2:0] f3_p0;
  logic [6:0] f7_p0;
  logic [5:0] op_p0;
  beat_t      dec_p0;
  logic       vld_p0;

  assign opcode_p0 = in_instr[6:0];
  assign f3_p0     = in_instr[14:12];
  assign f7_p0     = in_instr[31:25];

  always_comb begin
    dec_p0    = '0;
    op_p0     = 6'd0;
    dec_p0.pc = in_pc;
    case (opcode_p0)
      7'b0110111: begin dec_p0.rd = in_instr[11:7]; dec_p0.imm = imm_u(in_instr); op_p0 = 6'd1; end
      7'b0010111: begin dec_p0.rd = in_instr[11:7]; dec_p0.imm = imm_u(in_instr); op_p0 = 6'd2; end
      7'b1101111: begin dec_p0.rd = in_instr[11:7]; dec_p0.imm = imm_j(in_instr); op_p0 = 6'd3; end
      7'b1100111: begin
        dec_p0.rd  = in_instr[11:7];
        dec_p0.rs1 = in_instr[19:15];
        dec_p0.imm = imm_i(in_instr);
        if (f3_p0 == 3'b000) op_p0 = 6'd4;
      end
      7'b1100011: begin
        dec_p0.rs1 = in_instr[19:15];
        dec_p0.rs2 = in_instr[24:20];
        dec_p0.imm = imm_b(in_instr);
        case (f3_p0)
          3'b000:  op_p0 = 6'd5;
          3'b001:  op_p0 = 6'd6;
          3'b100:  op_p0 = 6'd7;
          3'b101:  op_p0 = 6'd8;
          3'b110:  op_p0 = 6'd9;
          3'b111:  op_p0 = 6'd10;
          default: op_p0 = 6'd0;
        endcase
      end
      7'b0000011: begin
        dec_p0.rd  = in_instr[11:7];
        dec_p0.rs1 = in_instr[19:15];
        dec_p0.imm = imm_i(in_instr);
        case (f3_p0)
          3'b000:  op_p0 = 6'd11;
          3'b001:  op_p0 = 6'd12;
          3'b010:  op_p0 = 6'd13;
          3'b100:  op_p0 = 6'd14;
          3'b101:  op_p0 = 6'd15;
          default: op_p0 = 6'd0;
        endcase
      end
      7'b0100011: begin
        dec_p0.rs1 = in_instr[19:15];
        dec_p0.rs2 = in_instr[24:20];
        dec_p0.imm = imm_s(in_instr);
        case (f3_p0)
          3'b000:  op_p0 = 6'd16;
          3'b001:  op_p0 = 6'd17;
          3'b010:  op_p0 = 6'd18;
          default: op_p0 = 6'd0;
        endcase
      end
      7'b0010011: begin
        dec_p0.rd  = in_instr[11:7];
        dec_p0.rs1 = in_instr[19:15];
        dec_p0.imm = imm_i(in_instr);
        case (f3_p0)
          3'b000: op_p0 = 6'd19;
          3'b010: op_p0 = 6'd20;
          3'b011: op_p0 = 6'd21;
          3'b100: op_p0 = 6'd22;
          3'b110: op_p0 = 6'd23;
          3'b111: op_p0 = 6'd24;
          // Shifts carry a zero-extended shamt even when funct7 makes them illegal.
          3'b001: begin
            dec_p0.imm = {{(XLEN-5){1'b0}}, in_instr[24:20]};
            if (f7_p0 == 7'b0000000) op_p0 = 6'd25;
          end
          default: begin
            dec_p0.imm = {{(XLEN-5){1'b0}}, in_instr[24:20]};
            if (f7_p0 == 7'b0000000)      op_p0 = 6'd26;
            else if (f7_p0 == 7'b0100000) op_p0 = 6'd27;
          end
        endcase
      end
      7'b0110011: begin
        dec_p0.rd  = in_instr[11:7];
        dec_p0.rs1 = in_instr[19:15];
        dec_p0.rs2 = in_instr[24:20];
        if (f7_p0 == 7'b0000000) begin
          case (f3_p0)
            3'b000:  op_p0 = 6'd28;
            3'b001:  op_p0 = 6'd30;
            3'b010:  op_p0 = 6'd31;
            3'b011:  op_p0 = 6'd32;
            3'b100:  op_p0 = 6'd33;
            3'b101:  op_p0 = 6'd34;
            3'b110:  op_p0 = 6'd36;
            default: op_p0 = 6'd37;
          endcase
        end else if (f7_p0 == 7'b0100000) begin
          if (f3_p0 == 3'b000)      op_p0 = 6'd29;
          else if (f3_p0 == 3'b101) op_p0 = 6'd35;
        end else if (f7_p0 == 7'b0000001 && ENABLE_M != 0) begin
          op_p0 = 6'd38 + {3'b000, f3_p0};
        end
      end
      default: ;
    endcase
    dec_p0.op      = op_p0;
    dec_p0.illegal = (op_p0 == 6'd0);
  end

  // ---- p1: two-slot FIFO, slot0 is always the head ----
  logic [1:0] cnt_p1;
  logic [1:0] cnt_nxt;
  beat_t      slot0_p1;
  beat_t      slot1_p1;
  logic       vld_p1;
  logic       pop_p1;

  assign vld_p0 = in_valid & in_ready & ~flush;
  assign vld_p1 = (cnt_p1 != 2'd0);
  assign pop_p1 = vld_p1 & out_ready;

  always_comb begin
    cnt_nxt = cnt_p1;
    if (flush)                cnt_nxt = 2'd0;
    else if (vld_p0 && !pop_p1) cnt_nxt = cnt_p1 + 2'd1;
    else if (!vld_p0 && pop_p1) cnt_nxt = cnt_p1 - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_p1   <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      cnt_p1   <= cnt_nxt;
      in_ready <= (cnt_nxt < 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (pop_p1 && cnt_p1 == 2'd2)                       slot0_p1 <= slot1_p1;
    else if (vld_p0 && (cnt_p1 == 2'd0 || pop_p1))      slot0_p1 <= dec_p0;
    if (vld_p0 && ((cnt_p1 == 2'd1 && !pop_p1) || (cnt_p1 == 2'd2 && pop_p1)))
      slot1_p1 <= dec_p0;
  end

  // Data outputs read as zero whenever no beat is presented.
  assign out_valid   = vld_p1;
  assign out_op      = vld_p1 ? slot0_p1.op      : '0;
  assign out_rd      = vld_p1 ? slot0_p1.rd      : '0;
  assign out_rs1     = vld_p1 ? slot0_p1.rs1     : '0;
  assign out_rs2     = vld_p1 ? slot0_p1.rs2     : '0;
  assign out_imm     = vld_p1 ? slot0_p1.imm     : '0;
  assign out_illegal = vld_p1 ? slot0_p1.illegal : 1'b0;
  assign out_pc      = vld_p1 ? slot0_p1.pc      : '0;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised RV32I instruction decode stage between fetch and execute.
- Accepts raw instruction words and PC through a valid/ready handshake.
- Emits a fully decoded op code, register indices, a correctly sign-extended immediate and an illegal flag.
- Includes a 2-entry skid buffer, so in_ready never depends combinationally on out_ready. Supports a pipeline flush and an optional M-extension decode mode.

Parameters:
- XLEN, 32, data/immediate width; valid values 32 or 64; immediates sign-extend to XLEN.
- ENABLE_M, 0, 1 = decode MUL..REMU; 0 = those encodings flag illegal.
- PC_W, 32, width of the PC passed through alongside the instruction.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- flush  in  1  drop all buffered and incoming beats this cycle.
- in_valid  in  1  fetch holds a valid instruction.
- in_ready  out  1  stage can accept a beat; registered.
- in_instr  in  32  raw instruction word.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  decoded beat available.
- out_ready  in  1  execute accepts the beat.
- out_op  out  6  decoded op code (encoding below).
- out_rd  out  5  destination register; 0 if the format has none.
- out_rs1  out  5  source 1; 0 if the format has none.
- out_rs2  out  5  source 2; 0 if the format has none.
- out_imm  out  XLEN  sign-extended immediate; 0 for R-type.
- out_illegal  out  1  unrecognised opcode/funct combination.
- out_pc  out  PC_W  PC of the decoded beat.

Behaviour:
- Reset (rstn=0 at posedge):
  - buffer emptied; out_valid=0, in_ready=0.
  - all data outputs 0.
  - in_ready goes to 1 on the first cycle after reset is released.
- Op encoding (unsigned):
  - 0 = none/illegal.
  - LUI=1, AUIPC=2, JAL=3, JALR=4.
  - BEQ,BNE,BLT,BGE,BLTU,BGEU = 5..10.
  - LB,LH,LW,LBU,LHU = 11..15; SB,SH,SW = 16..18.
  - ADDI,SLTI,SLTIU,XORI,ORI,ANDI,SLLI,SRLI,SRAI = 19..27.
  - ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND = 28..37.
  - MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU = 38..45 (only if ENABLE_M).
- Illegal detection: out_illegal=1 and out_op=0 when opcode/funct3/funct7 matches no enabled op. This includes:
  - shift-immediate or R-type with an invalid funct7;
  - JALR with funct3 != 0;
  - opcode[1:0] != 2'b11.
  - Field outputs still follow the opcode's format when it is known, else are 0.
- Immediates (bit 0 of B and J immediates is 0):
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25],instr[11:7]}).
  - B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - U: sext({instr[31:12],12'b0}).
  - J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - SLLI/SRLI/SRAI: imm = zero-extended shamt instr[24:20].
- Handshake:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - Output data is stable while out_valid=1 & out_ready=0.
- Buffer: 2-entry FIFO of decoded beats; decode is combinational before the write.
  - Latency: a beat accepted at edge N is visible on the outputs after edge N (1 cycle) when the buffer is empty.
  - in_ready = (count<2) registered, i.e. the next-cycle count must be <2.
  - Simultaneous push and pop at count=1 or 2 keeps the count unchanged, with order preserved.
  - Full throughput of 1 beat/cycle when out_ready is held at 1.
- Flush: synchronous and overrides everything.
  - Count goes to 0 and out_valid=0 after the edge.
  - A beat presented with in_valid in the flush cycle is discarded.
  - in_ready=1 next cycle.
- Reset mid-stream behaves as flush plus in_ready=0 for the reset cycles.

Test Plan:
- Reset then ADDI x1,x0,-1 (0xFFF00093) with out_ready=1 -> one cycle later: out_op=19, rd=1, rs1=0, rs2=0, imm=0xFFFFFFFF, illegal=0.
- BEQ x1,x2,-4 (0xFE208EE3) -> out_op=5, rs1=1, rs2=2, rd=0, imm=0xFFFFFFFC.
- LUI x5,0x12345 (0x123452B7) -> op=1, rd=5, imm=0x12345000.
- MUL x3,x1,x2 (0x022081B3) -> ENABLE_M=1: op=38, rd=3, rs1=1, rs2=2, illegal=0; ENABLE_M=0: op=0, illegal=1.
- Backpressure: stream 4 beats with out_ready=0 -> in_ready drops after 2 accepts and out_valid/data stay stable. Then out_ready=1 -> the 4 beats emerge in order with matching out_pc and no loss or duplication.
- Flush with 2 beats buffered and in_valid=1 -> next cycle out_valid=0, in_ready=1. The flushed and in-flight beats never appear on the output.
